// File: rtl/ddr_arb_pkg.sv
// Shared types for the two-master DDR simulation arbiter.
package ddr_arb_pkg;
    localparam int REQ_N = 2;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } arb_state_e;

    typedef logic owner_t;
endpackage

// File: rtl/ddr_arb_rr2.sv
// Two-way round-robin picker; ptr names the master that wins a tie.
module ddr_arb_rr2
    import ddr_arb_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  owner_t           ptr,
    output logic [REQ_N-1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (ptr == 1'b0) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end else begin
            gnt[1] = req[1];
            gnt[0] = req[0] & ~req[1];
        end
    end
endmodule

// File: rtl/ddr_sim_arbiter.sv
// Burst arbiter/sequencer between two masters and the single-port ram_ddr model.
module ddr_sim_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REQ_N-1:0]                  cmd_valid,
    output logic [REQ_N-1:0]                  cmd_ready,
    input  logic [REQ_N-1:0]                  cmd_we,
    input  logic [REQ_N-1:0][ADDR_SIZE-1:0]   cmd_addr,
    input  logic [REQ_N-1:0][LEN_W-1:0]       cmd_len,
    input  logic [REQ_N-1:0][DATA_WIDTH-1:0]  wdata,
    input  logic [REQ_N-1:0]                  wdata_valid,
    output logic [REQ_N-1:0]                  wdata_ready,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [REQ_N-1:0]                  rd_valid,
    output logic                              rd_last,
    output logic                              ram_ena,
    output logic                              ram_wea,
    output logic [ADDR_SIZE-1:0]              ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_din,
    input  logic [DATA_WIDTH-1:0]             ram_dout
);
    arb_state_e            state_q, state_d;
    owner_t                ptr_q, owner_q, gnt_id;
    owner_t                iss_owner_q;
    logic                  iss_last_q;
    logic [ADDR_SIZE-1:0]  cur_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [REQ_N-1:0]      gnt;
    logic                  take, wr_beat, rd_beat, burst_end;

    ddr_arb_rr2 u_rr (
        .req (cmd_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign gnt_id  = gnt[1];
    assign rd_data = ram_dout;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = '0;
        wdata_ready = '0;
        take        = 1'b0;
        wr_beat     = 1'b0;
        rd_beat     = 1'b0;
        burst_end   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = gnt;
                if (|gnt) begin
                    take    = 1'b1;
                    state_d = cmd_we[gnt_id] ? WR : RD;
                end
            end
            WR: begin
                wdata_ready[owner_q] = 1'b1;
                if (wdata_valid[owner_q]) begin
                    wr_beat = 1'b1;
                    if (cnt_q == '0) begin
                        burst_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            RD: begin
                rd_beat = 1'b1;
                if (cnt_q == '0) begin
                    burst_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cur_q       <= '0;
            cnt_q       <= '0;
            ram_ena     <= 1'b0;
            ram_wea     <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            iss_owner_q <= 1'b0;
            iss_last_q  <= 1'b0;
            rd_valid    <= '0;
            rd_last     <= 1'b0;
        end else begin
            ram_ena <= wr_beat | rd_beat;
            ram_wea <= wr_beat;
            if (take) begin
                owner_q <= gnt_id;
                cur_q   <= cmd_addr[gnt_id];
                cnt_q   <= cmd_len[gnt_id];
            end
            // Address wraps modulo 2^ADDR_SIZE by plain overflow.
            if (wr_beat | rd_beat) begin
                ram_addr    <= cur_q;
                cur_q       <= cur_q + 1'b1;
                cnt_q       <= cnt_q - 1'b1;
                iss_owner_q <= owner_q;
                iss_last_q  <= (cnt_q == '0);
            end
            if (wr_beat) ram_din <= wdata[owner_q];
            if (burst_end) ptr_q <= ~ptr_q;
            // Read return lines up with ram_ddr's one-cycle registered douta.
            rd_valid <= '0;
            if (ram_ena && !ram_wea) rd_valid[iss_owner_q] <= 1'b1;
            rd_last <= ram_ena & ~ram_wea & iss_last_q;
        end
    end
endmodule
